mrv1_wb_arbiter: RTL and testbench



---
 rtl/mrv1_wb_arbiter_if.sv | 37 +++
 rtl/mrv1_wb_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mrv1_wb_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mrv1_wb_arbiter_if.sv
// rtl/mrv1_wb_arbiter_if.sv - FU result / writeback channel bundle for mrv1_wb_arbiter
interface mrv1_wb_arbiter_if #(
    parameter int NUM_FU_P      = 4,
    parameter int DATA_WIDTH_P  = 32,
    parameter int ITAG_WIDTH_P  = 3,
    parameter int NUM_THREADS_P = 8
);
    localparam int TID_WIDTH_LP    = $clog2(NUM_THREADS_P);
    localparam int FU_IDX_WIDTH_LP = $clog2(NUM_FU_P);

    // FU result side
    logic [NUM_FU_P-1:0]                   fu_done_i;
    logic [NUM_FU_P-1:0][DATA_WIDTH_P-1:0] fu_res_data_i;
    logic [NUM_FU_P-1:0][ITAG_WIDTH_P-1:0] fu_itag_i;
    logic [NUM_FU_P-1:0][TID_WIDTH_LP-1:0] fu_tid_i;
    logic [NUM_FU_P-1:0]                   fu_wb_rdy_o;

    // register-file writeback side
    logic                       wb_vld_o;
    logic                       wb_rdy_i;
    logic [DATA_WIDTH_P-1:0]    wb_data_o;
    logic [ITAG_WIDTH_P-1:0]    wb_itag_o;
    logic [TID_WIDTH_LP-1:0]    wb_tid_o;
    logic [FU_IDX_WIDTH_LP-1:0] wb_fu_o;

    // arbiter view
    modport master (
        input  fu_done_i, fu_res_data_i, fu_itag_i, fu_tid_i, wb_rdy_i,
        output fu_wb_rdy_o, wb_vld_o, wb_data_o, wb_itag_o, wb_tid_o, wb_fu_o
    );

    // exec stage / register file view
    modport slave (
        output fu_done_i, fu_res_data_i, fu_itag_i, fu_tid_i, wb_rdy_i,
        input  fu_wb_rdy_o, wb_vld_o, wb_data_o, wb_itag_o, wb_tid_o, wb_fu_o
    );
endinterface

// File: rtl/mrv1_wb_arbiter.sv
// rtl/mrv1_wb_arbiter.sv - per-FU result slots with round-robin writeback arbitration; optional MRV1_WB_ARB_PERF_EN conflict counter
module mrv1_wb_arbiter #(
    parameter int NUM_FU_P      = 4,
    parameter int DATA_WIDTH_P  = 32,
    parameter int ITAG_WIDTH_P  = 3,
    parameter int NUM_THREADS_P = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    mrv1_wb_arbiter_if.master      bus_io
`ifdef MRV1_WB_ARB_PERF_EN
    ,
    output logic [31:0]            wb_conflict_cnt_o
`endif
);
    localparam int TID_WIDTH_LP    = $clog2(NUM_THREADS_P);
    localparam int FU_IDX_WIDTH_LP = $clog2(NUM_FU_P);
    localparam logic [FU_IDX_WIDTH_LP-1:0] LAST_IDX_LP = FU_IDX_WIDTH_LP'(NUM_FU_P - 1);

    logic [NUM_FU_P-1:0]                   slot_vld_q, slot_vld_d;
    logic [NUM_FU_P-1:0][DATA_WIDTH_P-1:0] slot_data_q, slot_data_d;
    logic [NUM_FU_P-1:0][ITAG_WIDTH_P-1:0] slot_itag_q, slot_itag_d;
    logic [NUM_FU_P-1:0][TID_WIDTH_LP-1:0] slot_tid_q, slot_tid_d;

    logic [FU_IDX_WIDTH_LP-1:0] rr_ptr_q, rr_ptr_d;
    logic                       lock_vld_q, lock_vld_d;
    logic [FU_IDX_WIDTH_LP-1:0] lock_idx_q, lock_idx_d;

    logic [FU_IDX_WIDTH_LP-1:0] grant_idx;
    logic [FU_IDX_WIDTH_LP-1:0] cand;
    logic                       found;
    logic                       wb_vld;
    logic                       xfer;
    logic [NUM_FU_P-1:0]        fu_rdy;
    logic [NUM_FU_P-1:0]        accept;

    assign wb_vld = |slot_vld_q;
    assign xfer   = wb_vld & bus_io.wb_rdy_i;

    // Grant selection: a stalled grant stays locked, otherwise round-robin from rr_ptr
    always_comb begin
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        if (lock_vld_q) begin
            grant_idx = lock_idx_q;
        end else begin
            for (int k = 0; k < NUM_FU_P; k++) begin
                cand = FU_IDX_WIDTH_LP'((int'(rr_ptr_q) + k) % NUM_FU_P);
                if (!found && slot_vld_q[cand]) begin
                    found     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    // Per-FU ready: slot empty, or being drained this cycle so it can refill
    always_comb begin
        fu_rdy = '0;
        for (int i = 0; i < NUM_FU_P; i++) begin
            fu_rdy[i] = ~rst_i & (~slot_vld_q[i] |
                        (xfer & (grant_idx == FU_IDX_WIDTH_LP'(i))));
        end
    end

    assign accept             = bus_io.fu_done_i & fu_rdy;
    assign bus_io.fu_wb_rdy_o = fu_rdy;

    // Writeback payload from the granted slot, zeroed when idle
    always_comb begin
        bus_io.wb_vld_o  = wb_vld;
        bus_io.wb_data_o = '0;
        bus_io.wb_itag_o = '0;
        bus_io.wb_tid_o  = '0;
        bus_io.wb_fu_o   = '0;
        if (wb_vld) begin
            bus_io.wb_data_o = slot_data_q[grant_idx];
            bus_io.wb_itag_o = slot_itag_q[grant_idx];
            bus_io.wb_tid_o  = slot_tid_q[grant_idx];
            bus_io.wb_fu_o   = grant_idx;
        end
    end

    // Slot next state: drain on transfer, refill on accept (refill wins)
    always_comb begin
        slot_vld_d  = slot_vld_q;
        slot_data_d = slot_data_q;
        slot_itag_d = slot_itag_q;
        slot_tid_d  = slot_tid_q;
        for (int i = 0; i < NUM_FU_P; i++) begin
            if (xfer && (grant_idx == FU_IDX_WIDTH_LP'(i))) begin
                slot_vld_d[i] = 1'b0;
            end
            if (accept[i]) begin
                slot_vld_d[i]  = 1'b1;
                slot_data_d[i] = bus_io.fu_res_data_i[i];
                slot_itag_d[i] = bus_io.fu_itag_i[i];
                slot_tid_d[i]  = bus_io.fu_tid_i[i];
            end
        end
    end

    // Arbitration next state: lock on stall, advance pointer past the winner on transfer
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        if (xfer) begin
            lock_vld_d = 1'b0;
            rr_ptr_d   = (grant_idx == LAST_IDX_LP) ? '0 : grant_idx + 1'b1;
        end else if (wb_vld) begin
            lock_vld_d = 1'b1;
            lock_idx_d = grant_idx;
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_vld_q  <= '0;
            slot_data_q <= '0;
            slot_itag_q <= '0;
            slot_tid_q  <= '0;
            rr_ptr_q    <= '0;
            lock_vld_q  <= 1'b0;
            lock_idx_q  <= '0;
        end else begin
            slot_vld_q  <= slot_vld_d;
            slot_data_q <= slot_data_d;
            slot_itag_q <= slot_itag_d;
            slot_tid_q  <= slot_tid_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_vld_q  <= lock_vld_d;
            lock_idx_q  <= lock_idx_d;
        end
    end

`ifdef MRV1_WB_ARB_PERF_EN
    logic [31:0]              conflict_cnt_q, conflict_cnt_d;
    logic [FU_IDX_WIDTH_LP:0] vld_cnt;
    logic                     conflict;

    // Conflict detect: several results waiting, or an FU being refused
    always_comb begin
        vld_cnt = '0;
        for (int i = 0; i < NUM_FU_P; i++) begin
            vld_cnt = vld_cnt + {{FU_IDX_WIDTH_LP{1'b0}}, slot_vld_q[i]};
        end
        conflict       = (vld_cnt >= (FU_IDX_WIDTH_LP+1)'(2)) |
                         (|(bus_io.fu_done_i & ~fu_rdy));
        conflict_cnt_d = conflict_cnt_q;
        if (conflict && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    // Saturating conflict counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign wb_conflict_cnt_o = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_mrv1_wb_arbiter.sv
// tb/tb_mrv1_wb_arbiter.sv - self-checking bench for mrv1_wb_arbiter
module tb_mrv1_wb_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int TW = 3;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    mrv1_wb_arbiter_if #(.NUM_FU_P(N), .DATA_WIDTH_P(DW), .ITAG_WIDTH_P(IW), .NUM_THREADS_P(8)) bus ();

`ifdef MRV1_WB_ARB_PERF_EN
    logic [31:0] conflict_cnt;
`endif

    mrv1_wb_arbiter #(.NUM_FU_P(N), .DATA_WIDTH_P(DW), .ITAG_WIDTH_P(IW), .NUM_THREADS_P(8)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .bus_io (bus)
`ifdef MRV1_WB_ARB_PERF_EN
        ,
        .wb_conflict_cnt_o (conflict_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    // stimulus payload per FU
    logic [DW-1:0] in_data [N];
    logic [IW-1:0] in_itag [N];
    logic [TW-1:0] in_tid  [N];

    // reference model: one held result per FU, a rotating start point, a held grant
    bit            m_vld  [N];
    logic [DW-1:0] m_data [N];
    logic [IW-1:0] m_itag [N];
    logic [TW-1:0] m_tid  [N];
    int            m_ptr;
    int            m_hold;
    longint        m_cnt;
    bit            acc [N];

    int            log_fu [$];
    logic [DW-1:0] log_data [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        if (m_hold >= 0) return m_hold;
        for (int k = 0; k < N; k++) begin
            if (m_vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic step(input bit r, input logic [N-1:0] d, input bit wr);
        bit            ev;
        int            eg;
        int            pop;
        bit            refused;
        logic [N-1:0]  er;
        rst_i        = r;
        bus.fu_done_i = d;
        bus.wb_rdy_i  = wr;
        for (int i = 0; i < N; i++) begin
            bus.fu_res_data_i[i] = in_data[i];
            bus.fu_itag_i[i]     = in_itag[i];
            bus.fu_tid_i[i]      = in_tid[i];
        end
        @(negedge clk);
        ev  = 1'b0;
        pop = 0;
        for (int i = 0; i < N; i++) begin
            if (m_vld[i]) begin
                ev = 1'b1;
                pop++;
            end
        end
        eg = exp_grant();
        for (int i = 0; i < N; i++) begin
            er[i] = !r && (!m_vld[i] || (ev && wr && eg == i));
        end
        check("fu_wb_rdy", 64'(bus.fu_wb_rdy_o), 64'(er));
        check("wb_vld", 64'(bus.wb_vld_o), 64'(ev));
        check("wb_fu", 64'(bus.wb_fu_o), ev ? 64'(eg) : 64'd0);
        check("wb_data", 64'(bus.wb_data_o), ev ? 64'(m_data[eg]) : 64'd0);
        check("wb_itag", 64'(bus.wb_itag_o), ev ? 64'(m_itag[eg]) : 64'd0);
        check("wb_tid", 64'(bus.wb_tid_o), ev ? 64'(m_tid[eg]) : 64'd0);
`ifdef MRV1_WB_ARB_PERF_EN
        check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
`endif
        for (int i = 0; i < N; i++) acc[i] = d[i] && er[i];
        if (r) begin
            for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
            m_ptr  = 0;
            m_hold = -1;
            m_cnt  = 0;
        end else begin
            refused = 1'b0;
            for (int i = 0; i < N; i++) if (d[i] && !er[i]) refused = 1'b1;
            if ((pop >= 2 || refused) && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (ev && wr) begin
                log_fu.push_back(eg);
                log_data.push_back(m_data[eg]);
                m_vld[eg] = 1'b0;
                m_ptr     = (eg + 1) % N;
                m_hold    = -1;
            end else if (ev) begin
                m_hold = eg;
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    m_vld[i]  = 1'b1;
                    m_data[i] = in_data[i];
                    m_itag[i] = in_itag[i];
                    m_tid[i]  = in_tid[i];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string tag, input int exp_fu [4]);
        check({tag, "_len"}, 64'(log_fu.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_fu.size()) check(tag, 64'(log_fu[i]), 64'(exp_fu[i]));
        end
    endtask

    initial begin
        int  exp_order [4];
        bit  pend [N];
        logic [N-1:0] dv;

        for (int i = 0; i < N; i++) begin
            in_data[i] = 32'h1000 + i;
            in_itag[i] = IW'(i);
            in_tid[i]  = TW'(i);
            pend[i]    = 1'b0;
        end
        rst_i         = 1'b1;
        bus.fu_done_i = '0;
        bus.wb_rdy_i  = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.fu_res_data_i[i] = '0;
            bus.fu_itag_i[i]     = '0;
            bus.fu_tid_i[i]      = '0;
        end
        m_ptr  = 0;
        m_hold = -1;
        m_cnt  = 0;
        for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
        @(posedge clk);
        #1;

        // reset held with every FU requesting
        for (int c = 0; c < 3; c++) step(1'b1, 4'b1111, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        check("rdy_after_reset", 64'(bus.fu_wb_rdy_o), 64'hF);

`ifdef MRV1_WB_ARB_PERF_EN
        // two valid slots for three cycles, then one refused done
        step(1'b0, 4'b0011, 1'b1);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0010, 1'b0);
        check("perf_cnt_4", 64'(conflict_cnt), 64'd4);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b0);
`endif

        // single FU result
        log_fu.delete();
        log_data.delete();
        in_data[1] = 32'hDEAD_BEEF;
        in_itag[1] = 3'd5;
        in_tid[1]  = 3'd3;
        step(1'b0, 4'b0010, 1'b1);
        check("single_vld", 64'(bus.wb_vld_o), 64'd1);
        check("single_data", 64'(bus.wb_data_o), 64'hDEAD_BEEF);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        check("single_count", 64'(log_fu.size()), 64'd1);

        // round-robin from reset
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < N; i++) in_data[i] = 32'h100 + i;
        log_fu.delete();
        step(1'b0, 4'b1111, 1'b1);
        for (int c = 0; c < 5; c++) step(1'b0, 4'b0000, 1'b1);
        exp_order = '{0, 1, 2, 3};
        check_log("rr_from_0", exp_order);

        // move pointer to 2 then repeat
        step(1'b0, 4'b0010, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        log_fu.delete();
        step(1'b0, 4'b1111, 1'b1);
        for (int c = 0; c < 5; c++) step(1'b0, 4'b0000, 1'b1);
        exp_order = '{2, 3, 0, 1};
        check_log("rr_from_2", exp_order);

        // backpressure lock on slot 2 while slot 0 fills
        in_data[2] = 32'hAAAA_5555;
        step(1'b0, 4'b0100, 1'b1);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0001, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 4'b0000, 1'b0);
            check("lock_fu", 64'(bus.wb_fu_o), 64'd2);
            check("lock_data", 64'(bus.wb_data_o), 64'hAAAA_5555);
        end
        log_fu.delete();
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        check("bp_len", 64'(log_fu.size()), 64'd2);
        if (log_fu.size() == 2) begin
            check("bp_first", 64'(log_fu[0]), 64'd2);
            check("bp_second", 64'(log_fu[1]), 64'd0);
        end

        // FU0 streaming back to back
        log_fu.delete();
        log_data.delete();
        for (int k = 1; k <= 8; k++) begin
            in_data[0] = 32'(k);
            step(1'b0, 4'b0001, 1'b1);
        end
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        check("stream_len", 64'(log_data.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < log_data.size()) begin
                check("stream_data", 64'(log_data[k]), 64'(k + 1));
                check("stream_fu", 64'(log_fu[k]), 64'd0);
            end
        end

        // random traffic; FUs hold refused results
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]    = 1'b1;
                    in_data[i] = $urandom;
                    in_itag[i] = IW'($urandom);
                    in_tid[i]  = TW'($urandom);
                end
                dv[i] = pend[i];
            end
            step(1'b0, dv, $urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) if (acc[i]) pend[i] = 1'b0;
        end
        for (int c = 0; c < 6; c++) step(1'b0, 4'b0000, 1'b1);
        check("drained", 64'(bus.wb_vld_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
